// File: rtl/accel_spi_reader_if.sv
// Board-side SPI pins and the sample/strobe pair handed to the spirit-level display.
interface accel_spi_reader_if;
  localparam int unsigned DATA_W = 16;

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] data;
  logic              latch;
  logic              busy;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, data, latch, busy,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, data, latch, busy,
    output spi_miso
  );
endinterface

// File: rtl/accel_spi_reader.sv
// SPI mode-3 master for an ADXL345-class accelerometer: one POWER_CTL write after
// reset, then a periodic two-byte axis burst read published on data/latch.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter logic [5:0]  AXIS_ADDR     = 6'h32
) (
  input logic               clk,
  input logic               rst,
  accel_spi_reader_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned TMR_W  = $clog2(SAMPLE_PERIOD);
  localparam int unsigned HALF_W = 6;
  localparam int unsigned SR_W   = 24;
  localparam int unsigned RX_W   = 16;

  // Half-period index at which CS is released: 2N+1 for an N-bit transfer.
  localparam logic [HALF_W-1:0] INIT_END = HALF_W'(2 * 16 + 1);
  localparam logic [HALF_W-1:0] READ_END = HALF_W'(2 * 24 + 1);
  localparam logic [SR_W-1:0]   INIT_CMD = {8'h2D, 8'h08, 8'h00};
  localparam logic [SR_W-1:0]   READ_CMD = {2'b11, AXIS_ADDR, 16'h0000};

  typedef enum logic [2:0] {
    ST_INIT,
    ST_GAP,
    ST_WAIT,
    ST_READ,
    ST_PUBLISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [SR_W-1:0]   tx_q, tx_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [15:0]       data_q, data_d;
  logic              latch_q, latch_d;
  logic              busy_q, busy_d;

  logic [HALF_W-1:0] half_inc;
  logic [HALF_W-1:0] last_half;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    data_d    = data_q;
    latch_d   = latch_q;
    half_inc  = half_q + HALF_W'(1);
    last_half = (state_q == ST_READ) ? READ_END : INIT_END;
    tmr_d     = (tmr_q == TMR_W'(SAMPLE_PERIOD - 1)) ? '0 : tmr_q + TMR_W'(1);

    case (state_q)
      ST_INIT, ST_READ: begin
        if (cs_n_q) begin
          // Only reachable in INIT: CS is still high straight out of reset.
          cs_n_d = 1'b0;
          tx_d   = INIT_CMD;
          cnt_d  = '0;
          half_d = '0;
        end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          half_d = half_inc;
          if (half_inc == last_half) begin
            cs_n_d = 1'b1;
            tx_d   = '0;
            if (state_q == ST_READ) begin
              // rx holds {first byte (LSB), second byte (MSB)}.
              data_d  = {rx_q[7:0], rx_q[15:8]};
              state_d = ST_PUBLISH;
            end else begin
              state_d = ST_GAP;
            end
          end else if (half_inc[0]) begin
            sclk_d = 1'b0;
            if (half_inc != HALF_W'(1)) tx_d = {tx_q[SR_W-2:0], 1'b0};
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[RX_W-2:0], bus.spi_miso};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PUBLISH: begin
        latch_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        // Latch entered high with cnt at 0, so it covers exactly two cycles.
        latch_d = latch_q && (cnt_q == '0);
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (tmr_q == TMR_W'(SAMPLE_PERIOD - 1)) begin
          cs_n_d  = 1'b0;
          tx_d    = READ_CMD;
          cnt_d   = '0;
          half_d  = '0;
          state_d = ST_READ;
        end
      end

      default: state_d = ST_INIT;
    endcase

    busy_d = ~cs_n_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      half_q  <= '0;
      tmr_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tmr_q   <= tmr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = tx_q[SR_W-1];
  assign bus.data     = data_q;
  assign bus.latch    = latch_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

Produces the signed tilt sample and latch strobe consumed by the spirit-level LED display. Acts as SPI master to an ADXL345-class accelerometer: one power-up configuration write after reset, then a periodic two-byte burst read of one axis. Each completed read is published on `data` and announced by a rising edge on `latch`. Sits between the board SPI pins and the display block.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period; legal range 2 or more.
- `SAMPLE_PERIOD`, 50000: clk cycles between consecutive read-transfer starts; must exceed 64*CLK_DIV.
- `AXIS_ADDR`, 6'h32: low data-register address of the axis (0x32 X, 0x34 Y).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sclk`  out  1  SPI clock, mode 3 (idles high).
- `spi_cs_n`  out  1  chip select, active low.
- `spi_mosi`  out  1  master data out, MSB first.
- `spi_miso`  in  1  slave data in.
- `data`  out  16  signed two's-complement sample {MSB byte, LSB byte}.
- `latch`  out  1  publish strobe; `data` is valid and stable at its rising edge.
- `busy`  out  1  high while `spi_cs_n` is low.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=1, `spi_mosi`=0, `data`=0, `latch`=0, `busy`=0. The sample timer is cleared and the FSM enters INIT.
- FSM states:
  - INIT: one 16-bit write, command 0x2D (write, single) then 0x08 (POWER_CTL measure).
  - GAP: CS high for 2*CLK_DIV cycles.
  - WAIT: hold until the sample timer expires.
  - READ: 24-bit transfer; command byte {1'b1 read, 1'b1 multibyte, AXIS_ADDR}, for example 0xF2 for X, then 16 dummy bits with MOSI=0.
  - PUBLISH: update `data` and pulse `latch`.
  - GAP: return to WAIT.
- Sequence: INIT → GAP → WAIT → READ → PUBLISH → GAP → WAIT.
- The first received byte is LSB and the second is MSB. `data` = {MSB, LSB} with no alteration; the device supplies sign extension.
- `data` changes only in PUBLISH. A corrupt or idle bus (MISO stuck high) still publishes the value received, for example 16'hFFFF.
- The sample timer is free-running from reset release, modulo SAMPLE_PERIOD. WAIT exits on the cycle the timer wraps to 0.
- Reset asserted in any state, including mid-transfer, forces reset values on the next edge. The partial shift register is discarded and INIT is repeated after release.

## Timing
- Transfer starts at cycle t0: `spi_cs_n` falls and bit N-1 is on MOSI.
- SCLK falls at t0+CLK_DIV*(2k+1) and rises at t0+CLK_DIV*(2k+2), for k=0..N-1.
- MOSI shifts to the next bit on each falling SCLK edge after the first.
- MISO is sampled in the clk cycle of each rising SCLK edge.
- `spi_cs_n` rises CLK_DIV cycles after the last rising SCLK edge, so CS is low for (2N+1)*CLK_DIV cycles.
- Read transfer: N=24, CS low 49*CLK_DIV cycles. Init transfer: N=16.
- PUBLISH: `data` updates on the cycle CS rises (cycle P). `latch` goes high at P+1 and stays high for 2 cycles, low at P+3.
- Latency from read start t0 to the `latch` rising edge: 49*CLK_DIV+1 cycles.
- Read starts are spaced exactly SAMPLE_PERIOD cycles apart.
- `busy` is registered and equals ~`spi_cs_n` in the same cycle.

## Test plan
- Reset release, CLK_DIV=4:
  - MOSI bytes 0x2D, 0x08.
  - 16 SCLK rising edges with `spi_cs_n` low for 132 cycles.
  - `latch` stays 0 throughout.
- First read, AXIS_ADDR=0x32, MISO model returns 0x38 then 0xFF:
  - Command byte 0xF2.
  - `data`=16'hFF38 (-200).
  - `latch` rises 197 cycles after CS falls and is high for 2 cycles.
- MISO model returns 0x19 then 0x00:
  - `data`=16'h0019 (+25).
  - Previous `data` is held until the publish cycle.
- SAMPLE_PERIOD=1000:
  - Successive read `spi_cs_n` falling edges are exactly 1000 cycles apart over 5 reads.
  - `spi_sclk` stays high whenever CS is high.
- Reset pulsed 1 cycle at bit 10 of a read:
  - Next edge: `spi_cs_n`=1, `spi_sclk`=1, `data`=0, `latch`=0.
  - After release, the 0x2D/0x08 init repeats before any read.
- AXIS_ADDR=0x34: command byte 0xF4, and `data` reflects the model's Y bytes.
